fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the (pc, instruction, pc+4) packet consumed by the IF/ID pipeline register. It generates sequential fetch addresses and drives a request/response instruction-memory port with at most one request outstanding. A one-entry skid buffer absorbs a response that returns while ID is stalled. A redirect from a branch or jump resolves in a later stage, flushes queued fetches and discards any in-flight response.

## Interface

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset
- NOP_INSTR, 32'h00000013, instruction presented whenever o_valid=0 (addi x0,x0,0)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_stall  in  1  ID not accepting; the packet on o_* is held
- i_redirect  in  1  one-cycle pulse that changes the fetch stream
- i_redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0
- o_imem_req  out  1  instruction-memory request (combinational)
- o_imem_addr  out  32  request address, equal to fetch_pc
- i_imem_ready  in  1  memory accepts the request this cycle
- i_imem_rvalid  in  1  response valid; responses arrive in order, at least 1 cycle after acceptance
- i_imem_rdata  in  32  response instruction
- o_valid  out  1  fetch packet valid
- o_pc  out  32  PC of the packet
- o_instruction  out  32  instruction, or NOP_INSTR when o_valid=0
- o_pc_plus_4  out  32  o_pc + 4, modulo 2^32

## Operation

- Internal state:
  - fetch_pc
  - pend (one request accepted, no response yet) and pend_pc
  - drop (the pending response is stale)
  - skid_valid, skid_pc, skid_instr
  - output register (o_valid, o_pc, o_instruction)
- Output handshake: a packet transfers to ID when o_valid=1 and i_stall=0. The output register may load in that same cycle.
- Request logic:
  - Issue condition: o_imem_req = i_rst_n & !i_redirect & !skid_valid & (!pend | i_imem_rvalid) & !(i_imem_rvalid & !drop & o_valid & i_stall).
  - The last term guarantees that a response to a new request always finds an empty skid buffer.
  - Acceptance = o_imem_req & i_imem_ready. On acceptance: pend=1, pend_pc=fetch_pc, fetch_pc += 4 (wraps modulo 2^32).
  - If a request is not accepted it is retried next cycle at the same address. The address changes only through a redirect, and o_imem_req is low during a redirect cycle.
- Response handling (i_imem_rvalid):
  - pend is cleared unless a new acceptance occurs in the same cycle.
  - If drop=1 or i_redirect=1, the response is discarded and drop is cleared.
  - Otherwise, if the output register is free (!o_valid | !i_stall), it loads {1, pend_pc, rdata}.
  - Otherwise, the skid buffer loads {1, pend_pc, rdata}.
- Skid buffer:
  - When skid_valid=1 and the output register is free, the skid contents move to the output register and skid_valid clears.
  - A skid entry and a live response never coincide, because pend=0 while skid_valid=1.
- Empty output: when the output register is free and nothing loads it, o_valid=0 and o_instruction=NOP_INSTR. o_pc and o_pc_plus_4 hold their values.
- Redirect has priority over every other event in its cycle:
  - fetch_pc <= {i_redirect_pc[31:2], 2'b00}
  - o_valid <= 0 and o_instruction <= NOP_INSTR
  - skid_valid <= 0
  - If pend=1 and no response arrives this cycle, drop <= 1.
  - No request is issued in the redirect cycle.
  - A redirect while drop=1 keeps drop=1.
- An unexpected rvalid with pend=0 is ignored.

## Timing

- Reset values (asynchronous, while i_rst_n=0):
  - fetch_pc=RESET_PC, pend=0, drop=0, skid_valid=0
  - o_valid=0, o_pc=RESET_PC, o_instruction=NOP_INSTR, o_pc_plus_4=RESET_PC+4
  - o_imem_req=0
- First request: in the first cycle with i_rst_n=1.
- Latency: a request accepted in cycle N with rvalid in cycle N+1 yields o_valid=1 from cycle N+2.
- Throughput: one instruction per cycle with a 1-cycle-latency memory, ready=1 and no stall. A new request is issued in the same cycle as the previous response.
- Redirect in cycle R: the first request to the new address is in cycle R+1.
- Reset asserted mid-operation clears everything immediately. Any response in flight at that point is the environment's responsibility.

## Test plan

- Reset release, RESET_PC=0, 1-cycle memory returning addr|0xAB000000, no stall -> requests 0x0,0x4,0x8 on consecutive cycles; packets pc=0,4,8 with pc+4=4,8,C, one per cycle from cycle 2.
- i_stall held for 3 cycles while packet pc=0x8 is valid -> o_* hold pc=0x8; response for 0xC goes into the skid buffer; no further request; after release, 0x8 then 0xC transfer on consecutive cycles with no loss or duplication.
- Memory with 3-cycle latency and i_imem_ready low for 2 cycles -> o_imem_addr is stable while o_imem_req=1; never more than one request outstanding; packets remain in order.
- Redirect to 0x103 while the request for 0x10 is pending -> the 0x10 response is discarded; o_valid=0 with a NOP in the next cycle; the next request and packet are at 0x100.
- Redirect in the same cycle as a response, and a redirect with skid_valid=1 -> both the response and the skid entry are discarded; only packets from the new address appear.
- fetch_pc=0xFFFFFFFC -> packet pc+4=0x00000000; next request is to 0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding imem
// port, one-entry skid buffer and redirect flush toward the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_plus_4
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        drop_q, drop_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic out_free;
    logic rsp;
    logic req;
    logic accept;

    assign out_free = !out_valid_q || !i_stall;
    // A response with nothing pending is spurious and ignored.
    assign rsp      = i_imem_rvalid && pend_q;
    assign req      = i_rst_n && !i_redirect && !skid_valid_q
                   && (!pend_q || i_imem_rvalid)
                   && !(i_imem_rvalid && !drop_q && out_valid_q && i_stall);
    assign accept   = req && i_imem_ready;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        drop_d       = drop_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;

        if (out_free) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
        end

        if (skid_valid_q && out_free) begin
            out_valid_d  = 1'b1;
            out_pc_d     = skid_pc_q;
            out_instr_d  = skid_instr_q;
            skid_valid_d = 1'b0;
        end

        if (accept) begin
            pend_d     = 1'b1;
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (rsp) begin
            pend_d = 1'b0;
        end

        if (rsp) begin
            if (drop_q || i_redirect) begin
                drop_d = 1'b0;
            end else if (out_free) begin
                out_valid_d = 1'b1;
                out_pc_d    = pend_pc_q;
                out_instr_d = i_imem_rdata;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = pend_pc_q;
                skid_instr_d = i_imem_rdata;
            end
        end

        // Redirect wins over everything else in its cycle.
        if (i_redirect) begin
            fetch_pc_d   = i_redirect_pc & ~32'd3;
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            skid_valid_d = 1'b0;
            if (pend_q && !i_imem_rvalid) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q   <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= RESET_PC;
            drop_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            out_valid_q  <= 1'b0;
            out_pc_q     <= RESET_PC;
            out_instr_q  <= NOP_INSTR;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            drop_q       <= drop_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    assign o_imem_req    = req;
    assign o_imem_addr   = fetch_pc_q;
    assign o_valid       = out_valid_q;
    assign o_pc          = out_pc_q;
    assign o_instruction = out_instr_q;
    assign o_pc_plus_4   = out_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a program-order
// scoreboard of transferred packets and expected request addresses.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;

    always #5 clk = ~clk;

    fetch_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ready (imem_ready),
        .i_imem_rvalid(imem_rvalid),
        .i_imem_rdata (imem_rdata),
        .o_valid      (valid),
        .o_pc         (pc),
        .o_instruction(instr),
        .o_pc_plus_4  (pc4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory content: equals addr|0xAB000000 for low addresses, unique overall.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[31:24] ^ 8'hAB, a[23:0]};
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    int          cyc = 0;
    int          xfers = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_req = 32'h0;
    bit          post_redirect = 0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_pc4, s_instr;

    // One clock: drive inputs, let the memory answer, check, then advance.
    task automatic cycle(input bit st, input bit rdy, input bit rd,
                         input logic [31:0] rpc, input int lat);
        @(negedge clk);
        rst_n       = 1'b1;
        stall       = st;
        imem_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(memq[0].addr);
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid;
        s_pc    = pc;
        s_pc4   = pc4;
        s_instr = instr;
        if (post_redirect) check("valid_after_redirect", {31'b0, valid}, 32'h0);
        post_redirect = rd;
        if (!valid) check("nop_when_invalid", instr, NOP);
        check("pc_plus_4", pc4, pc + 32'd4);
        if (rd) check("req_in_redirect", {31'b0, imem_req}, 32'h0);
        if (imem_req) check("req_addr", imem_addr, exp_req);
        if (valid && !st && !rd) begin
            check("pkt_pc", pc, exp_pc);
            check("pkt_instr", instr, mem_data(exp_pc));
            exp_pc = exp_pc + 32'd4;
            xfers++;
        end
        if (imem_rvalid) void'(memq.pop_front());
        if (imem_req && rdy) begin
            check("outstanding", memq.size(), 32'h0);
            memq.push_back('{addr: imem_addr, due: cyc + lat});
            exp_req = exp_req + 32'd4;
        end
        if (rd) begin
            exp_req = rpc & ~32'd3;
            exp_pc  = rpc & ~32'd3;
        end
        cyc++;
    endtask

    // Directed stream: stall window, then redirect while 0x10 is pending.
    bit          d_st   [13] = '{0,0,0,0,1,1,1,0,0,0,0,0,0};
    bit          d_rd   [13] = '{0,0,0,0,0,0,0,0,0,1,0,0,0};
    bit          d_req  [13] = '{1,1,1,1,0,0,0,0,1,0,1,1,1};
    bit          d_val  [13] = '{0,0,1,1,1,1,1,1,1,0,0,0,1};
    logic [31:0] d_addr [13] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h10, 32'h0, 32'h100,
                                 32'h104, 32'h108};
    logic [31:0] d_pc   [13] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'h8,
                                 32'h8, 32'h8, 32'hC, 32'h0, 32'h0, 32'h0,
                                 32'h100};

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_pc4", pc4, 32'h4);
        check("rst_req", {31'b0, imem_req}, 32'h0);

        for (int k = 0; k < 13; k++) begin
            cycle(d_st[k], 1'b1, d_rd[k], 32'h103, (k == 8) ? 2 : 1);
            check($sformatf("d_req%0d", k), {31'b0, s_req}, {31'b0, d_req[k]});
            if (d_req[k]) check($sformatf("d_addr%0d", k), s_addr, d_addr[k]);
            check($sformatf("d_valid%0d", k), {31'b0, s_valid},
                  {31'b0, d_val[k]});
            if (d_val[k]) check($sformatf("d_pc%0d", k), s_pc, d_pc[k]);
            else check($sformatf("d_nop%0d", k), s_instr, NOP);
        end

        // Wrap at the top of the address space.
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        check("wrap_req0", s_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        check("wrap_req1", s_addr, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1);
        check("wrap_pc", s_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", s_pc4, 32'h0);

        // Random traffic: stalls, not-ready, variable latency, redirects.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(2) == 0, $urandom_range(2) != 0,
                  $urandom_range(19) == 0,
                  ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15)
                                           : $urandom,
                  $urandom_range(1, 3));
        end
        check("progress", {31'b0, xfers > 300}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
